// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are formed at issue and retired after a fixed, data-independent latency.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MC = 4'(MULT_CYCLES);
    localparam logic [3:0] DC = 4'(DIV_CYCLES);

    logic [3:0]  cnt;
    logic [31:0] p_hi, p_lo;

    logic [63:0] prod_s, prod_u;
    logic [31:0] mag_a, mag_b, sq, sr, uq, ur;
    logic [31:0] d_hi, d_lo, du_hi, du_lo;

    logic        ld;
    logic [3:0]  ld_cnt;
    logic [31:0] res_hi, res_lo;
    logic        wr_hi, wr_lo;

    assign busy = (cnt != 4'd0);

    // Signed divide works on magnitudes so INT_MIN / -1 wraps naturally.
    always_comb begin
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'b0, a} * {32'b0, b};
        mag_a  = a[31] ? -a : a;
        mag_b  = b[31] ? -b : b;
        sq     = mag_a / mag_b;
        sr     = mag_a % mag_b;
        uq     = a / b;
        ur     = a % b;
        if (b == 32'd0) begin
            d_hi  = a;
            d_lo  = 32'hFFFF_FFFF;
            du_hi = a;
            du_lo = 32'hFFFF_FFFF;
        end else begin
            d_hi  = a[31] ? -sr : sr;
            d_lo  = (a[31] ^ b[31]) ? -sq : sq;
            du_hi = ur;
            du_lo = uq;
        end
    end

    always_comb begin
        ld     = 1'b0;
        ld_cnt = 4'd0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        wr_hi  = 1'b0;
        wr_lo  = 1'b0;
        unique case (1'b1)
            (op == OP_MULT): begin
                ld     = 1'b1;
                ld_cnt = MC;
                res_hi = prod_s[63:32];
                res_lo = prod_s[31:0];
            end
            (op == OP_MULTU): begin
                ld     = 1'b1;
                ld_cnt = MC;
                res_hi = prod_u[63:32];
                res_lo = prod_u[31:0];
            end
            (op == OP_DIV): begin
                ld     = 1'b1;
                ld_cnt = DC;
                res_hi = d_hi;
                res_lo = d_lo;
            end
            (op == OP_DIVU): begin
                ld     = 1'b1;
                ld_cnt = DC;
                res_hi = du_hi;
                res_lo = du_lo;
            end
            (op == OP_MTHI): wr_hi = 1'b1;
            (op == OP_MTLO): wr_lo = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= 4'd0;
            p_hi <= 32'd0;
            p_lo <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                hi <= p_hi;
                lo <= p_lo;
            end
        end else if (start) begin
            if (ld) begin
                cnt  <= ld_cnt;
                p_hi <= res_hi;
                p_lo <= res_lo;
            end
            if (wr_hi) hi <= a;
            if (wr_lo) lo <= a;
        end
    end

endmodule
